// File: rtl/gaussian_pkg.sv
// ============================================================================
// Module   : gaussian_pkg
// Purpose  : Shared constants and types for the 5x5 Gaussian window feeder.
//            This package holds the kernel weights, the normaliser and the
//            control-state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gaussian_pkg;

  // Window edge length. The window holds GAUSS_TAPS columns of GAUSS_TAPS rows.
  localparam int GAUSS_TAPS = 5;

  // Sum of all kernel weights. The weighted sum is divided by this value.
  localparam int GAUSS_NORM = 159;

  // Integer kernel, indexed [column][row]. It is symmetric in both axes.
  localparam int GAUSS_KERNEL [GAUSS_TAPS][GAUSS_TAPS] = '{
    '{2,  4,  5,  4, 2},
    '{4,  9, 12,  9, 4},
    '{5, 12, 15, 12, 5},
    '{4,  9, 12,  9, 4},
    '{2,  4,  5,  4, 2}
  };

  // Control states: accept columns, fire the divide, await quotient, present pixel.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } gauss_state_e;

endpackage : gaussian_pkg

`default_nettype wire

// File: rtl/gaussian_weighted_adder.sv
// ============================================================================
// Module   : gaussian_weighted_adder
// Purpose  : Purely combinational 25-term multiply-add over the 5x5 window.
//            Each pixel is multiplied by its kernel weight, and the products
//            are accumulated into one SUM_WIDTH result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gaussian_weighted_adder
  import gaussian_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int SUM_WIDTH   = 16
) (
  // Column c occupies [c*5*PIXEL_WIDTH +: 5*PIXEL_WIDTH]; row r within it at [r*PIXEL_WIDTH +: PIXEL_WIDTH]
  input  logic [GAUSS_TAPS*GAUSS_TAPS*PIXEL_WIDTH-1:0] window_i,
  output logic [SUM_WIDTH-1:0]                         sum_o
);

  localparam int NTAPS = GAUSS_TAPS * GAUSS_TAPS;

  // Tap k maps to column k/5 and row k%5, so the flat bit offset is simply k*PIXEL_WIDTH.
  // Each tap adds its product onto the running total of the previous tap.
  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    logic [SUM_WIDTH-1:0] w_term;
    logic [SUM_WIDTH-1:0] w_acc;

    assign w_term = SUM_WIDTH'(GAUSS_KERNEL[k / GAUSS_TAPS][k % GAUSS_TAPS])
                  * SUM_WIDTH'(window_i[k*PIXEL_WIDTH +: PIXEL_WIDTH]);

    if (k == 0) begin : g_first
      assign w_acc = w_term;
    end else begin : g_next
      assign w_acc = g_tap[k-1].w_acc + w_term;
    end
  end

  assign sum_o = g_tap[NTAPS-1].w_acc;

endmodule : gaussian_weighted_adder

`default_nettype wire

// File: rtl/gaussian_window_sum.sv
// ============================================================================
// Module   : gaussian_window_sum
// Purpose  : Keeps a 5x5 sliding pixel window built from incoming columns.
//            It issues one divide request (weighted sum / 159) per full window,
//            stalls until the quotient returns, and then presents the
//            saturated 8-bit blurred pixel with a ready/valid handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gaussian_window_sum
  import gaussian_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int SUM_WIDTH   = 16,
  parameter int NORM_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [GAUSS_TAPS*PIXEL_WIDTH-1:0] in_col,
  input  logic                              in_row_start,
  output logic                              in_ready,
  output logic                              div_valid,
  output logic [SUM_WIDTH-1:0]              div_dividend,
  output logic [NORM_WIDTH-1:0]             div_divisor,
  input  logic                              div_done,
  input  logic [SUM_WIDTH-1:0]              div_quotient,
  output logic                              out_valid,
  output logic [PIXEL_WIDTH-1:0]            out_pixel,
  input  logic                              out_ready
);

  localparam int         COL_WIDTH = GAUSS_TAPS * PIXEL_WIDTH;
  localparam int         PIX_MAX   = (1 << PIXEL_WIDTH) - 1;
  localparam logic [2:0] FILL_FULL = 3'(GAUSS_TAPS);

  // window_q[0] is the newest column and window_q[4] the oldest
  logic [GAUSS_TAPS-1:0][COL_WIDTH-1:0] window_q;
  logic [2:0]                           fill_q;
  logic [2:0]                           fill_d;
  gauss_state_e                         state_q;
  logic                                 in_ready_q;
  logic                                 div_valid_q;
  logic                                 out_valid_q;
  logic [PIXEL_WIDTH-1:0]               result_q;

  logic                                 w_accept;
  logic [PIXEL_WIDTH-1:0]               w_quot_sat;

  // in_ready_q is high only in IDLE, so this also means "accepting in IDLE"
  assign w_accept = in_valid & in_ready_q;

  // The divider output can exceed the pixel range in principle, so clamp it to full scale
  assign w_quot_sat = (div_quotient > SUM_WIDTH'(PIX_MAX)) ? {PIXEL_WIDTH{1'b1}}
                                                           : div_quotient[PIXEL_WIDTH-1:0];

  // Fill count after an accepted column: a row start restarts at 1, otherwise count saturates at full
  always_comb begin
    fill_d = fill_q;
    if (in_row_start) begin
      fill_d = 3'd1;
    end else if (fill_q != FILL_FULL) begin
      fill_d = fill_q + 3'd1;
    end
  end

  // Column shift register, which only moves on an accepted column and stays frozen otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_q <= '0;
    end else if (w_accept) begin
      window_q <= {window_q[GAUSS_TAPS-2:0], in_col};
    end
  end

  // Control FSM with registered handshake outputs, fill counter and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fill_q      <= 3'd0;
      in_ready_q  <= 1'b1;
      div_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            fill_q <= fill_d;
            if (fill_d == FILL_FULL) begin
              state_q     <= ISSUE;
              in_ready_q  <= 1'b0;
              div_valid_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          div_valid_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            result_q    <= w_quot_sat;
            out_valid_q <= 1'b1;
            state_q     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          div_valid_q <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  gaussian_weighted_adder #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .SUM_WIDTH   (SUM_WIDTH)
  ) u_adder (
    .window_i (window_q),
    .sum_o    (div_dividend)
  );

  assign in_ready    = in_ready_q;
  assign div_valid   = div_valid_q;
  assign out_valid   = out_valid_q;
  assign out_pixel   = result_q;
  assign div_divisor = NORM_WIDTH'(GAUSS_NORM);

endmodule : gaussian_window_sum

`default_nettype wire

// File: tb/tb_gaussian_window_sum.sv
// ============================================================================
// Module   : tb_gaussian_window_sum
// Purpose  : Bench for gaussian_window_sum, driven through a behavioural
//            multi-cycle unsigned divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gaussian_window_sum;

  localparam int PW  = 8;
  localparam int SW  = 16;
  localparam int NW  = 8;
  localparam int LAT = 4;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [5*PW-1:0] in_col;
  logic          in_row_start;
  logic          in_ready;
  logic          div_valid;
  logic [SW-1:0] div_dividend;
  logic [NW-1:0] div_divisor;
  logic          div_done;
  logic [SW-1:0] div_quotient;
  logic          out_valid;
  logic [PW-1:0] out_pixel;
  logic          out_ready;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // Reference kernel and column history since the last row start (newest at the back)
  int kern [5][5] = '{'{2,4,5,4,2}, '{4,9,12,9,4}, '{5,12,15,12,5}, '{4,9,12,9,4}, '{2,4,5,4,2}};
  logic [5*PW-1:0] hist [$];

  gaussian_window_sum #(.PIXEL_WIDTH(PW), .SUM_WIDTH(SW), .NORM_WIDTH(NW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_col       (in_col),
    .in_row_start (in_row_start),
    .in_ready     (in_ready),
    .div_valid    (div_valid),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .out_valid    (out_valid),
    .out_pixel    (out_pixel),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider stand-in: takes a request, answers floor(dividend/divisor) LAT cycles later
  logic          dv_busy;
  int            dv_cnt;
  logic [SW-1:0] dv_q;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dv_busy <= 1'b0; dv_cnt <= 0; dv_q <= '0;
      div_done <= 1'b0; div_quotient <= '0;
    end else begin
      div_done <= 1'b0;
      if (dv_busy) begin
        if (dv_cnt == 1) begin
          div_done <= 1'b1; div_quotient <= dv_q; dv_busy <= 1'b0;
        end else begin
          dv_cnt <= dv_cnt - 1;
        end
      end else if (div_valid) begin
        dv_busy <= 1'b1; dv_cnt <= LAT;
        dv_q <= (div_divisor == 0) ? '1 : SW'(div_dividend / div_divisor);
      end
    end
  end

  always @(posedge clk) if (div_valid === 1'b1) pulses <= pulses + 1;

  // Weighted sum over the five most recent columns of the current row
  function automatic int model_sum();
    int s = 0;
    for (int c = 0; c < 5; c++) begin
      logic [5*PW-1:0] col = hist[hist.size()-1-c];
      for (int r = 0; r < 5; r++) s += kern[c][r] * int'(col[r*PW +: PW]);
    end
    return s;
  endfunction

  function automatic int model_pixel(input int s);
    int q = s / 159;
    return (q > 255) ? 255 : q;
  endfunction

  function automatic logic [5*PW-1:0] uni(input logic [PW-1:0] p);
    return {5{p}};
  endfunction

  // Present a column and hold it until accepted; updates the history on acceptance
  task automatic drive_col(input logic [5*PW-1:0] col, input bit rs, output bit to);
    int n = 0;
    to = 1'b0;
    in_col = col; in_row_start = rs; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (in_ready !== 1'b1) begin
      to = 1'b1;
    end else begin
      @(posedge clk); #1;
      if (rs) hist.delete();
      hist.push_back(col);
    end
    in_valid = 1'b0; in_row_start = 1'b0;
  endtask

  // Observe one request/result transaction and complete the output handshake
  task automatic collect(output logic [SW-1:0] dvd, output logic [NW-1:0] dvs,
                         output logic [PW-1:0] pix, output logic rdy_emit, output bit to);
    int n = 0;
    to = 1'b0; dvd = '0; dvs = '0; pix = '0; rdy_emit = 1'b0;
    while (div_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (div_valid !== 1'b1) begin to = 1'b1; return; end
    dvd = div_dividend; dvs = div_divisor;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (out_valid !== 1'b1) begin to = 1'b1; return; end
    pix = out_pixel; rdy_emit = in_ready;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_col = '0; in_row_start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (div_valid !== 1'b0) begin bad++; $display("FAIL reset_div_valid: got %b want 0", div_valid); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_pixel !== 8'd0) begin bad++; $display("FAIL reset_out_pixel: got %0d want 0", out_pixel); end
    total++; if (div_dividend !== 16'd0) begin bad++; $display("FAIL reset_dividend: got %0d want 0", div_dividend); end
    total++; if (div_divisor !== 8'd159) begin bad++; $display("FAIL reset_divisor: got %0d want 159", div_divisor); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_255();
    bit to; logic [SW-1:0] dvd; logic [NW-1:0] dvs; logic [PW-1:0] pix; logic re; int p0, s;
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      drive_col(uni(8'd255), i == 0, to);
      total++; if (to) begin bad++; $display("FAIL all255_accept: got timeout want accept col %0d", i); end
    end
    s = model_sum();
    collect(dvd, dvs, pix, re, to);
    total++; if (to) begin bad++; $display("FAIL all255_txn: got timeout want result"); end
    total++; if (dvd !== SW'(s)) begin bad++; $display("FAIL all255_dividend: got %0d want %0d", dvd, s); end
    total++; if (dvs !== 8'd159) begin bad++; $display("FAIL all255_divisor: got %0d want 159", dvs); end
    total++; if (pix !== PW'(model_pixel(s))) begin bad++; $display("FAIL all255_pixel: got %0d want %0d", pix, model_pixel(s)); end
    repeat (4) @(negedge clk);
    total++; if (pulses - p0 != 1) begin bad++; $display("FAIL all255_pulses: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_back_to_back();
    bit to; logic [SW-1:0] dvd; logic [NW-1:0] dvs; logic [PW-1:0] pix; logic re; int s;
    for (int i = 0; i < 5; i++) drive_col(uni(8'd100), i == 0, to);
    s = model_sum();
    collect(dvd, dvs, pix, re, to);
    total++; if (to || pix !== PW'(model_pixel(s))) begin bad++; $display("FAIL b2b_first_pixel: got %0d want %0d (timeout=%0d)", pix, model_pixel(s), to); end
    total++; if (re !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_emit: got %b want 0", re); end
    drive_col(uni(8'd100), 1'b0, to);
    total++; if (to || in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_after_accept: got %b want 0 (timeout=%0d)", in_ready, to); end
    s = model_sum();
    collect(dvd, dvs, pix, re, to);
    total++; if (to || dvd !== SW'(s)) begin bad++; $display("FAIL b2b_second_dividend: got %0d want %0d (timeout=%0d)", dvd, s, to); end
    total++; if (pix !== PW'(model_pixel(s))) begin bad++; $display("FAIL b2b_second_pixel: got %0d want %0d", pix, model_pixel(s)); end
  endtask

  task automatic test_centre();
    bit to; logic [SW-1:0] dvd; logic [NW-1:0] dvs; logic [PW-1:0] pix; logic re; int s;
    logic [5*PW-1:0] centre;
    centre = {8'd0, 8'd0, 8'd255, 8'd0, 8'd0};
    for (int i = 0; i < 5; i++) drive_col((i == 2) ? centre : '0, i == 0, to);
    s = model_sum();
    collect(dvd, dvs, pix, re, to);
    total++; if (to || dvd !== SW'(s)) begin bad++; $display("FAIL centre_dividend: got %0d want %0d (timeout=%0d)", dvd, s, to); end
    total++; if (pix !== PW'(model_pixel(s))) begin bad++; $display("FAIL centre_pixel: got %0d want %0d", pix, model_pixel(s)); end
  endtask

  task automatic test_row_start();
    bit to; logic [SW-1:0] dvd; logic [NW-1:0] dvs; logic [PW-1:0] pix; logic re; int p0, s;
    p0 = pulses;
    for (int i = 0; i < 3; i++) drive_col({$urandom, 8'($urandom)}, i == 0, to);
    for (int i = 0; i < 4; i++) drive_col({$urandom, 8'($urandom)}, i == 0, to);
    repeat (6) @(negedge clk);
    total++; if (pulses != p0) begin bad++; $display("FAIL rowstart_early_issue: got %0d pulses want 0", pulses - p0); end
    drive_col({$urandom, 8'($urandom)}, 1'b0, to);
    s = model_sum();
    collect(dvd, dvs, pix, re, to);
    total++; if (to || dvd !== SW'(s)) begin bad++; $display("FAIL rowstart_dividend: got %0d want %0d (timeout=%0d)", dvd, s, to); end
    total++; if (pix !== PW'(model_pixel(s))) begin bad++; $display("FAIL rowstart_pixel: got %0d want %0d", pix, model_pixel(s)); end
  endtask

  task automatic test_backpressure();
    bit to; int n, p0, s, exp_pix;
    for (int i = 0; i < 5; i++) drive_col({$urandom, 8'($urandom)}, i == 0, to);
    exp_pix = model_pixel(model_sum());
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_reach_emit: got out_valid=%b want 1", out_valid); end
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_pixel !== PW'(exp_pix)) begin bad++; $display("FAIL bp_hold_output: got valid=%b pixel=%0d want 1/%0d", out_valid, out_pixel, exp_pix); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
    end
    total++; if (pulses != p0) begin bad++; $display("FAIL bp_no_new_issue: got %0d pulses want 0", pulses - p0); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    s = 0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    bit to; logic [SW-1:0] dvd; logic [NW-1:0] dvs; logic [PW-1:0] pix; logic re; int n, p0, s;
    for (int i = 0; i < 5; i++) drive_col(uni(8'(50 + i)), i == 0, to);
    n = 0;
    while (div_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1 || div_valid !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL midreset_handshake: got ready=%b dv=%b ov=%b want 1/0/0", in_ready, div_valid, out_valid); end
    total++; if (out_pixel !== 8'd0 || div_dividend !== 16'd0) begin bad++; $display("FAIL midreset_data: got pixel=%0d dividend=%0d want 0/0", out_pixel, div_dividend); end
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    p0 = pulses;
    for (int i = 0; i < 4; i++) drive_col({$urandom, 8'($urandom)}, 1'b0, to);
    repeat (8) @(negedge clk);
    total++; if (pulses != p0 || out_valid !== 1'b0) begin bad++; $display("FAIL midreset_fill_zero: got pulses=%0d ov=%b want 0/0", pulses - p0, out_valid); end
    drive_col({$urandom, 8'($urandom)}, 1'b0, to);
    s = model_sum();
    collect(dvd, dvs, pix, re, to);
    total++; if (to || dvd !== SW'(s) || pix !== PW'(model_pixel(s))) begin bad++; $display("FAIL midreset_result: got %0d/%0d want %0d/%0d (timeout=%0d)", dvd, pix, s, model_pixel(s), to); end
  endtask

  task automatic test_random();
    bit to; logic [SW-1:0] dvd; logic [NW-1:0] dvs; logic [PW-1:0] pix; logic re; int p0, s;
    logic [5*PW-1:0] col;
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 5; r++) begin
        case ($urandom_range(0, 3))
          0: col[r*PW +: PW] = 8'd0;
          1: col[r*PW +: PW] = 8'd255;
          default: col[r*PW +: PW] = 8'($urandom);
        endcase
      end
      p0 = pulses;
      drive_col(col, (it == 0) || ($urandom_range(0, 7) == 0), to);
      if (hist.size() >= 5) begin
        s = model_sum();
        collect(dvd, dvs, pix, re, to);
        total++; if (to || dvd !== SW'(s)) begin bad++; $display("FAIL rand_dividend: it=%0d got %0d want %0d (timeout=%0d)", it, dvd, s, to); end
        total++; if (pix !== PW'(model_pixel(s))) begin bad++; $display("FAIL rand_pixel: it=%0d got %0d want %0d", it, pix, model_pixel(s)); end
      end else begin
        repeat (3) @(negedge clk);
        total++; if (pulses != p0) begin bad++; $display("FAIL rand_no_issue: it=%0d got %0d pulses want 0", it, pulses - p0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_255();
    test_back_to_back();
    test_centre();
    test_row_start();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_gaussian_window_sum

`default_nettype wire
